axi_ram_slave: RTL

- AXI3 responder modelling main memory behind a single on-chip word array, one transaction in flight at a time.
- Answers the cache's AXI burst master on AR/R and AW/W/B; used as the memory model in cache-level simulation and as a simple on-chip RAM in FPGA bring-up.
- Supports FIXED, INCR and WRAP bursts of 1-16 beats, 32-bit beats, byte strobes and ID echo.

---
 rtl/axi_pkg.sv | 26 ++
 rtl/axi_ram_slave_if.sv | 65 ++++++
 rtl/axi_burst_addr.sv | 45 ++++
 rtl/axi_ram_slave.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI3 constants and the responder state type.
//                Burst encodings, response codes and the four-state
//                transaction FSM enum used by axi_ram_slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RDATA = 2'd1,
    WDATA = 2'd2,
    BRESP = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/axi_ram_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_ram_slave_if
//  Description : AXI3 read/write channel bundle (AR, R, AW, W, B) without
//                lock/cache/prot. The slave modport is the responder view,
//                the master modport is the requester view.
//  Ports       : none; parameter ID_W sets the ID width.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_ram_slave_if #(
  parameter int ID_W = 4
) ();

  // Read address / data
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  // Write address / data / response
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

endinterface
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_addr
//  Description : Combinational next-beat word address for AXI bursts.
//                FIXED holds, INCR adds one (mod 2^ADDR_LEN), WRAP rolls the
//                low log2(len+1) bits. WRAP with a length other than
//                2/4/8/16 beats, and the reserved burst code, behave as INCR.
//  Ports       : i_cur   - current word address
//                i_len   - beats-1 (4 bits)
//                i_burst - burst type
//                o_next  - word address of the following beat
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_LEN = 12
) (
  input  wire logic [ADDR_LEN-1:0] i_cur,
  input  wire logic [3:0]          i_len,
  input  wire logic [1:0]          i_burst,
  output logic      [ADDR_LEN-1:0] o_next
);

  logic [ADDR_LEN-1:0] w_incr;
  logic [ADDR_LEN-1:0] w_mask;
  logic                w_wrap_ok;

  assign w_incr    = i_cur + {{(ADDR_LEN-1){1'b0}}, 1'b1};
  // For legal wrap lengths len itself is the all-ones mask of the wrap window.
  assign w_mask    = {{(ADDR_LEN-4){1'b0}}, i_len};
  assign w_wrap_ok = (i_len == 4'd1) || (i_len == 4'd3) ||
                     (i_len == 4'd7) || (i_len == 4'd15);

  always_comb begin
    o_next = w_incr;
    if (i_burst == BURST_FIXED) begin
      o_next = i_cur;
    end else if ((i_burst == BURST_WRAP) && w_wrap_ok) begin
      o_next = (i_cur & ~w_mask) | (w_incr & w_mask);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_ram_slave
//  Description : AXI3 responder over a 2^ADDR_LEN x 32-bit word array. One
//                transaction in flight; writes win simultaneous requests.
//                FIXED/INCR/WRAP bursts of 1-16 beats, byte strobes, ID echo,
//                SLVERR when wlast disagrees with the beat count.
//  Ports       : aclk    - clock, rising edge
//                aresetn - asynchronous active-low reset
//                s_axi   - AXI channel bundle, slave modport
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_LEN = 12,
  parameter int ID_W     = 4
) (
  input  wire logic       aclk,
  input  wire logic       aresetn,
  axi_ram_slave_if.slave  s_axi
);

  localparam int c_DEPTH = 1 << ADDR_LEN;

  logic [31:0]         r_mem [c_DEPTH];

  state_e              r_state;
  logic                r_req_rdy;
  logic [ADDR_LEN-1:0] r_cur;
  logic [3:0]          r_len;
  logic [3:0]          r_beat;
  logic [1:0]          r_burst;
  logic [ID_W-1:0]     r_id;
  logic                r_err;
  logic                r_rvalid;
  logic                r_rlast;
  logic [31:0]         r_rdata;
  logic [ID_W-1:0]     r_rid;
  logic                r_wready;
  logic                r_bvalid;
  logic [ID_W-1:0]     r_bid;
  logic [1:0]          r_bresp;

  logic [ADDR_LEN-1:0] w_next;
  logic [ADDR_LEN-1:0] w_ar_word;
  logic [ADDR_LEN-1:0] w_aw_word;
  logic                w_aw_hs;
  logic                w_ar_hs;
  logic                w_last_beat;
  logic                w_wr_en;
  logic                w_wlast_bad;

  axi_burst_addr #(.ADDR_LEN(ADDR_LEN)) u_burst_addr (
    .i_cur   (r_cur),
    .i_len   (r_len),
    .i_burst (r_burst),
    .o_next  (w_next)
  );

  assign w_ar_word   = s_axi.araddr[ADDR_LEN+1:2];
  assign w_aw_word   = s_axi.awaddr[ADDR_LEN+1:2];
  // r_req_rdy is only ever set while idle, so it doubles as the IDLE qualifier.
  assign w_aw_hs     = r_req_rdy && s_axi.awvalid;
  assign w_ar_hs     = r_req_rdy && !s_axi.awvalid && s_axi.arvalid;
  assign w_last_beat = (r_beat == r_len);
  assign w_wr_en     = (r_state == WDATA) && s_axi.wvalid;
  assign w_wlast_bad = (s_axi.wlast != w_last_beat);

  assign s_axi.awready = r_req_rdy;
  assign s_axi.arready = r_req_rdy && !s_axi.awvalid;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rid     = r_rid;
  assign s_axi.rresp   = RESP_OKAY;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bid     = r_bid;
  assign s_axi.bresp   = r_bresp;

  // Memory is never reset; beats already committed survive a mid-burst reset.
  always_ff @(posedge aclk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi.wstrb[i]) begin
          r_mem[r_cur][8*i +: 8] <= s_axi.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_req_rdy <= 1'b0;
      r_cur     <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_burst   <= BURST_FIXED;
      r_id      <= '0;
      r_err     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rid     <= '0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_req_rdy) begin
            // First cycle out of reset: open the request channels.
            r_req_rdy <= 1'b1;
          end else if (w_aw_hs) begin
            r_req_rdy <= 1'b0;
            r_id      <= s_axi.awid;
            r_cur     <= w_aw_word;
            r_len     <= s_axi.awlen[3:0];
            r_burst   <= s_axi.awburst;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_wready  <= 1'b1;
            r_state   <= WDATA;
          end else if (w_ar_hs) begin
            r_req_rdy <= 1'b0;
            r_id      <= s_axi.arid;
            r_rid     <= s_axi.arid;
            r_cur     <= w_ar_word;
            r_len     <= s_axi.arlen[3:0];
            r_burst   <= s_axi.arburst;
            r_beat    <= '0;
            r_rvalid  <= 1'b1;
            r_rdata   <= r_mem[w_ar_word];
            r_rlast   <= (s_axi.arlen[3:0] == 4'd0);
            r_state   <= RDATA;
          end
        end
        RDATA: begin
          if (s_axi.rready) begin
            if (w_last_beat) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_req_rdy <= 1'b1;
              r_state   <= IDLE;
            end else begin
              // Prefetch the next beat so rdata stays a registered output.
              r_beat  <= r_beat + 4'd1;
              r_cur   <= w_next;
              r_rdata <= r_mem[w_next];
              r_rlast <= ((r_beat + 4'd1) == r_len);
            end
          end
        end
        WDATA: begin
          if (s_axi.wvalid) begin
            if (w_wlast_bad) begin
              r_err <= 1'b1;
            end
            if (w_last_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= (r_err || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              r_state  <= BRESP;
            end else begin
              r_beat <= r_beat + 4'd1;
              r_cur  <= w_next;
            end
          end
        end
        BRESP: begin
          if (s_axi.bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_err     <= 1'b0;
            r_req_rdy <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
